// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - accumulator datapath: PC, IR, ACC, carry flag, 16x8 register file, ALU
module cpu_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic        LoadIR,
    input  logic        IncPC,
    input  logic        SelPC,
    input  logic        LoadPC,
    input  logic        LoadReg,
    input  logic        DumpReg,
    input  logic        LoadAcc,
    input  logic [1:0]  SelAcc,
    input  logic [3:0]  SelALU,
    input  logic [3:0]  SelReg,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    output logic [7:0]  Opcode,
    output logic        Zero_Carry,
    output logic [7:0]  acc_out,
    output logic [7:0]  reg_bus
);

    localparam logic [3:0] ALU_PASSB = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_NOT   = 4'b0110;
    localparam logic [3:0] ALU_SHL   = 4'b0111;
    localparam logic [3:0] ALU_SHR   = 4'b1000;

    logic [7:0]  pc;
    logic [15:0] ir;
    logic [7:0]  acc;
    logic        carry;
    logic [7:0]  regs [16];

    logic [7:0]  reg_rd;
    logic [7:0]  alu_res;
    logic        alu_cout;
    logic        alu_sets_carry;
    logic [8:0]  sum9;
    logic [7:0]  acc_next;

    // Register read is combinational, so a same-cycle write is seen only after the edge.
    assign reg_rd     = regs[SelReg];
    assign sum9       = {1'b0, acc} + {1'b0, reg_rd};
    assign imem_addr  = pc;
    assign Opcode     = ir[15:8];
    assign acc_out    = acc;
    assign reg_bus    = DumpReg ? reg_rd : 8'h00;
    assign Zero_Carry = ir[15] ? carry : (acc != 8'h00);

    // ALU: A is ACC, B is the selected register; carry-out only meaningful for arithmetic/shift ops.
    always_comb begin
        alu_res        = acc;
        alu_cout       = 1'b0;
        alu_sets_carry = 1'b0;
        case (SelALU)
            ALU_PASSB: alu_res = reg_rd;
            ALU_ADD: begin
                alu_res        = sum9[7:0];
                alu_cout       = sum9[8];
                alu_sets_carry = 1'b1;
            end
            ALU_SUB: begin
                alu_res        = acc - reg_rd;
                alu_cout       = (acc < reg_rd);
                alu_sets_carry = 1'b1;
            end
            ALU_AND: alu_res = acc & reg_rd;
            ALU_OR:  alu_res = acc | reg_rd;
            ALU_XOR: alu_res = acc ^ reg_rd;
            ALU_NOT: alu_res = ~acc;
            ALU_SHL: begin
                alu_res        = {acc[6:0], 1'b0};
                alu_cout       = acc[7];
                alu_sets_carry = 1'b1;
            end
            ALU_SHR: begin
                alu_res        = {1'b0, acc[7:1]};
                alu_cout       = acc[0];
                alu_sets_carry = 1'b1;
            end
            default: alu_res = acc;
        endcase
    end

    // ACC source mux; 11 re-selects the current ACC.
    always_comb begin
        acc_next = acc;
        case (SelAcc)
            2'b00:   acc_next = alu_res;
            2'b01:   acc_next = ir[7:0];
            2'b10:   acc_next = reg_rd;
            default: acc_next = acc;
        endcase
    end

    // PC, IR, ACC and carry update; reset wins over every strobe, IncPC wins over LoadPC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= 8'h00;
            ir    <= 16'h0000;
            acc   <= 8'h00;
            carry <= 1'b0;
        end else begin
            if (LoadIR) ir <= imem_data;
            if (IncPC) begin
                pc <= pc + 8'h01;
            end else if (LoadPC) begin
                pc <= SelPC ? ir[7:0] : reg_rd;
            end
            if (LoadAcc) begin
                acc <= acc_next;
                if (SelAcc == 2'b00 && alu_sets_carry) carry <= alu_cout;
            end
        end
    end

    // Register file write takes the pre-edge ACC even when ACC is loaded in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else if (LoadReg) begin
            regs[SelReg] <= acc;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - self-checking bench for cpu_datapath with a behavioural model
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg, LoadAcc;
    logic [1:0]  SelAcc;
    logic [3:0]  SelALU, SelReg;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  Opcode;
    logic        Zero_Carry;
    logic [7:0]  acc_out, reg_bus;

    int total = 0;
    int bad   = 0;

    int m_pc, m_ir, m_acc, m_c;
    int m_reg [16];

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk(clk), .reset(reset), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
        .LoadPC(LoadPC), .LoadReg(LoadReg), .DumpReg(DumpReg), .LoadAcc(LoadAcc),
        .SelAcc(SelAcc), .SelALU(SelALU), .SelReg(SelReg), .imem_addr(imem_addr),
        .imem_data(imem_data), .Opcode(Opcode), .Zero_Carry(Zero_Carry),
        .acc_out(acc_out), .reg_bus(reg_bus)
    );

    task automatic idle();
        reset = 0; LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0; LoadReg = 0;
        DumpReg = 0; LoadAcc = 0; SelAcc = 2'b11; SelALU = 4'h0; SelReg = 4'h0;
        imem_data = 16'h0000;
    endtask

    // Applies one clock edge to both the model and the DUT, then compares every output.
    task automatic cycle(input string tag);
        int a, b, res, cout, n_pc, n_ir, n_acc, n_c, exp_zc, exp_bus;
        bit arith;
        a = m_acc; b = m_reg[SelReg];
        arith = 0; cout = 0;
        case (SelALU)
            0: res = b;
            1: begin res = a + b; cout = res / 256; arith = 1; end
            2: begin res = a - b; cout = (a < b) ? 1 : 0; arith = 1; end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = 255 - a;
            7: begin res = a * 2; cout = a / 128; arith = 1; end
            8: begin res = a / 2; cout = a % 2; arith = 1; end
            default: res = a;
        endcase
        res = res & 255;
        n_pc = m_pc; n_ir = m_ir; n_acc = m_acc; n_c = m_c;
        if (LoadIR) n_ir = imem_data;
        if (IncPC) n_pc = (m_pc + 1) % 256;
        else if (LoadPC) n_pc = SelPC ? (m_ir % 256) : b;
        if (LoadAcc) begin
            case (SelAcc)
                0: n_acc = res;
                1: n_acc = m_ir % 256;
                2: n_acc = b;
                default: n_acc = m_acc;
            endcase
            if (SelAcc == 0 && arith) n_c = cout;
        end
        @(posedge clk);
        if (reset) begin
            m_pc = 0; m_ir = 0; m_acc = 0; m_c = 0;
            for (int i = 0; i < 16; i++) m_reg[i] = 0;
        end else begin
            if (LoadReg) m_reg[SelReg] = m_acc;
            m_pc = n_pc; m_ir = n_ir; m_acc = n_acc; m_c = n_c;
        end
        #1;
        exp_zc  = (m_ir >= 32768) ? m_c : ((m_acc != 0) ? 1 : 0);
        exp_bus = DumpReg ? m_reg[SelReg] : 0;
        total++;
        if (imem_addr !== m_pc[7:0]) begin
            bad++; $display("FAIL %s imem_addr got=%h exp=%h", tag, imem_addr, m_pc[7:0]);
        end
        total++;
        if (Opcode !== m_ir[15:8]) begin
            bad++; $display("FAIL %s Opcode got=%h exp=%h", tag, Opcode, m_ir[15:8]);
        end
        total++;
        if (acc_out !== m_acc[7:0]) begin
            bad++; $display("FAIL %s acc_out got=%h exp=%h", tag, acc_out, m_acc[7:0]);
        end
        total++;
        if (Zero_Carry !== exp_zc[0]) begin
            bad++; $display("FAIL %s Zero_Carry got=%b exp=%b", tag, Zero_Carry, exp_zc[0]);
        end
        total++;
        if (reg_bus !== exp_bus[7:0]) begin
            bad++; $display("FAIL %s reg_bus got=%h exp=%h", tag, reg_bus, exp_bus[7:0]);
        end
    endtask

    task automatic load_ir(input logic [15:0] w);
        idle(); LoadIR = 1; imem_data = w; cycle("load_ir");
    endtask

    task automatic load_imm_acc(input logic [15:0] w);
        load_ir(w);
        idle(); LoadAcc = 1; SelAcc = 2'b01; cycle("load_acc");
    endtask

    task automatic test_reset();
        idle(); reset = 1; cycle("reset");
        idle(); reset = 1; cycle("reset2");
        total++;
        if (imem_addr !== 8'h00 || Opcode !== 8'h00 || Zero_Carry !== 1'b0 || acc_out !== 8'h00 || reg_bus !== 8'h00) begin
            bad++; $display("FAIL reset_outputs got=%h/%h/%b/%h/%h exp=0", imem_addr, Opcode, Zero_Carry, acc_out, reg_bus);
        end
    endtask

    task automatic test_fetch();
        idle(); LoadIR = 1; IncPC = 1; imem_data = 16'h4203; cycle("fetch");
        total++;
        if (Opcode !== 8'h42 || imem_addr !== 8'h01) begin
            bad++; $display("FAIL fetch got op=%h pc=%h exp op=42 pc=01", Opcode, imem_addr);
        end
    endtask

    task automatic test_add_carry();
        load_imm_acc(16'h8020);
        idle(); LoadReg = 1; SelReg = 4'd3; cycle("reg3");
        load_imm_acc(16'h80F0);
        idle(); LoadAcc = 1; SelAcc = 2'b00; SelALU = 4'b0001; SelReg = 4'd3; cycle("add");
        total++;
        if (acc_out !== 8'h10 || Zero_Carry !== 1'b1) begin
            bad++; $display("FAIL add_carry got acc=%h zc=%b exp acc=10 zc=1", acc_out, Zero_Carry);
        end
    endtask

    task automatic test_sub_zero();
        load_imm_acc(16'h6005);
        idle(); LoadReg = 1; SelReg = 4'd2; cycle("reg2");
        idle(); LoadAcc = 1; SelAcc = 2'b00; SelALU = 4'b0010; SelReg = 4'd2; cycle("sub");
        total++;
        if (acc_out !== 8'h00 || Zero_Carry !== 1'b0 || Opcode !== 8'h60) begin
            bad++; $display("FAIL sub_zero got acc=%h zc=%b op=%h exp acc=00 zc=0 op=60", acc_out, Zero_Carry, Opcode);
        end
        load_ir(16'h8000);
        total++;
        if (Zero_Carry !== 1'b0) begin
            bad++; $display("FAIL sub_borrow got c=%b exp c=0", Zero_Carry);
        end
    endtask

    task automatic test_jump();
        load_ir(16'h00FF);
        idle(); LoadPC = 1; SelPC = 1; cycle("pc_ff");
        idle(); IncPC = 1; cycle("pc_wrap");
        total++;
        if (imem_addr !== 8'h00) begin
            bad++; $display("FAIL pc_wrap got=%h exp=00", imem_addr);
        end
        load_ir(16'h003C);
        idle(); LoadPC = 1; SelPC = 1; cycle("jump");
        total++;
        if (imem_addr !== 8'h3C) begin
            bad++; $display("FAIL jump got=%h exp=3C", imem_addr);
        end
        idle(); LoadPC = 1; SelPC = 1; IncPC = 1; cycle("inc_over_load");
        total++;
        if (imem_addr !== 8'h3D) begin
            bad++; $display("FAIL inc_priority got=%h exp=3D", imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        load_imm_acc(16'h00AA);
        load_ir(16'h0055);
        idle(); LoadReg = 1; LoadAcc = 1; SelAcc = 2'b01; SelReg = 4'd7; cycle("reg_acc_same");
        idle(); DumpReg = 1; SelReg = 4'd7; #1;
        total++;
        if (reg_bus !== 8'hAA || acc_out !== 8'h55) begin
            bad++; $display("FAIL reg_acc_same got reg=%h acc=%h exp reg=AA acc=55", reg_bus, acc_out);
        end
    endtask

    task automatic test_reset_override();
        load_imm_acc(16'h8077);
        idle(); reset = 1; LoadAcc = 1; SelAcc = 2'b01; LoadReg = 1; SelReg = 4'd9;
        LoadPC = 1; SelPC = 1; LoadIR = 1; imem_data = 16'hFFFF; cycle("reset_override");
        idle(); DumpReg = 1;
        for (int i = 0; i < 16; i++) begin
            SelReg = i[3:0]; #1;
            total++;
            if (reg_bus !== 8'h00) begin
                bad++; $display("FAIL reset_regs idx=%0d got=%h exp=00", i, reg_bus);
            end
        end
        total++;
        if (imem_addr !== 8'h00 || acc_out !== 8'h00 || Opcode !== 8'h00 || Zero_Carry !== 1'b0) begin
            bad++; $display("FAIL reset_override got pc=%h acc=%h op=%h zc=%b exp 0", imem_addr, acc_out, Opcode, Zero_Carry);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            LoadIR    = $urandom_range(0, 1);
            IncPC     = ($urandom_range(0, 3) == 0);
            SelPC     = $urandom_range(0, 1);
            LoadPC    = $urandom_range(0, 1);
            LoadReg   = $urandom_range(0, 1);
            DumpReg   = $urandom_range(0, 1);
            LoadAcc   = $urandom_range(0, 1);
            SelAcc    = 2'($urandom_range(0, 3));
            SelALU    = 4'($urandom_range(0, 15));
            SelReg    = 4'($urandom_range(0, 15));
            imem_data = 16'($urandom);
            cycle("random");
        end
    endtask

    initial begin
        m_pc = 0; m_ir = 0; m_acc = 0; m_c = 0;
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        idle();
        test_reset();
        test_fetch();
        test_add_carry();
        test_sub_zero();
        test_jump();
        test_back_to_back();
        test_reset_override();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 Single clock, clk; reset is synchronous and active-high; all state updates occur on posedge clk only.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg, LoadAcc  input  1 each  control strobes from the controller.
REQ-005 SelAcc  input  2  ACC source select: 00 ALU, 01 immediate, 10 register bus, 11 hold.
REQ-006 SelALU  input  4  ALU operation select.
REQ-007 SelReg  input  4  register-file index, 0-15.
REQ-008 imem_addr  output  8  instruction memory address; always equals PC.
REQ-009 imem_data  input  16  instruction word; combinational read of imem_addr.
REQ-010 Opcode  output  8  IR[15:8], registered.
REQ-011 Zero_Carry  output  1  branch condition to the controller.
REQ-012 acc_out  output  8  current ACC value.
REQ-013 reg_bus  output  8  Reg[SelReg] when DumpReg=1, else 8'h00.

Function
REQ-014 State: PC[7:0], IR[15:0], ACC[7:0], carry flag C, register file Reg[0..15] of 8 bits each.
REQ-015 LoadIR=1: IR <= imem_data in the same edge; Opcode is valid the cycle after LoadIR.
REQ-016 PC update priority: IncPC=1 gives PC <= PC+1, else LoadPC=1 gives PC <= (SelPC ? IR[7:0] : Reg[SelReg]), else PC holds.
REQ-017 PC increment wraps 8'hFF to 8'h00, with no flag.
REQ-018 LoadReg=1: Reg[SelReg] <= ACC, using the pre-edge ACC even when LoadAcc=1 in the same cycle.
REQ-019 Register reads are combinational; a read of the index being written in the same cycle returns the old value.
REQ-020 LoadAcc=1: ACC <= mux(SelAcc) of {ALU result, IR[7:0], Reg[SelReg], ACC}; LoadAcc=0 holds ACC.
REQ-021 ALU operands: A = ACC, B = Reg[SelReg], independent of DumpReg.
REQ-022 SelALU 0000 PASS B; 0001 ADD A+B; 0010 SUB A-B; 0011 AND; 0100 OR; 0101 XOR; 0110 NOT A; 0111 SHL A by 1; 1000 SHR A by 1; 1001-1111 PASS A.
REQ-023 ALU result is the low 8 bits of the result; carry-out is 9th bit for ADD, borrow (A<B) for SUB, A[7] for SHL, A[0] for SHR, and 0 otherwise.
REQ-024 C <= carry-out only when LoadAcc=1, SelAcc=00 and SelALU is ADD, SUB, SHL or SHR; in all other cases C holds.
REQ-025 Zero_Carry = C when Opcode[7]=1, else Zero_Carry = (ACC != 0), so 0 means ACC is zero.
REQ-026 Zero_Carry is combinational from registered state, with no path from control inputs.
REQ-027 Control combinations are all legal and independent; any subset of strobes may be asserted in one cycle.

Reset
REQ-028 reset=1 at an edge: PC=0, IR=16'h0000, ACC=0, C=0, and all 16 registers=0.
REQ-029 Reset overrides every control strobe in the same cycle.
REQ-030 Mid-operation reset discards any in-flight update; the first fetch after reset reads address 0.
REQ-031 After reset, outputs are: imem_addr=0, Opcode=0, Zero_Carry=0, acc_out=0, reg_bus=0.

Verification
REQ-032 Reset, then LoadIR+IncPC with imem_data=16'h4203 -> Opcode=8'h42 and imem_addr=1.
REQ-033 Sequence:
- ACC=8'hF0 via SelAcc=01 and IR[7:0]=F0.
- Reg[3]=8'h20.
- ADD (LoadAcc, SelAcc=00, SelALU=0001, SelReg=3).
-> ACC=8'h10, C=1; with Opcode[7]=1, Zero_Carry=1.
REQ-034 ACC=5, Reg[2]=5, SUB -> ACC=0, C=0; with Opcode=8'h60, Zero_Carry=0.
REQ-035 Jump sequence:
- PC=8'hFF with IncPC -> PC=0.
- Then LoadPC with SelPC=1 and IR[7:0]=8'h3C -> PC=8'h3C.
- IncPC+LoadPC together -> PC=8'h3D.
REQ-036 ACC=8'hAA, LoadReg and LoadAcc (SelAcc=01, imm=8'h55) with SelReg=7 in one cycle -> Reg[7]=8'hAA and ACC=8'h55.
REQ-037 Assert reset while LoadAcc, LoadReg and LoadPC are active -> all state is zero next cycle and no register write occurs.
